mac_dot_sequencer: RTL and testbench

Initiator and collector for the 8-bit 2-stage MAC pipeline. Accepts a stream of VEC_LEN operand pairs via valid/ready and issues one MAC operation per accepted pair. Sums the returned 16-bit products into a dot product and presents the sum on a valid/ready output port. Sits between the operand fetch logic and the mixer-layer output buffer.

---
 rtl/mlp_pkg.sv | 23 ++
 rtl/dot_acc.sv | 52 +++++
 rtl/mac_dot_sequencer.sv | 111 +++++++++++
 tb/tb_mac_dot_sequencer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mlp_pkg.sv
// ============================================================================
//  Module      : mlp_pkg
//  Description : Shared MAC pipeline widths, latency and sequencer states.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mlp_pkg;

   localparam int OP_W    = 8;
   localparam int PROD_W  = 16;
   localparam int MAC_LAT = 2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISSUE  = 2'd1,
      DRAIN  = 2'd2,
      OUTPUT = 2'd3
   } state_t;

endpackage

`default_nettype wire

// File: rtl/dot_acc.sv
// ============================================================================
//  Module      : dot_acc
//  Description : Dot-product accumulator and returned-product counter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dot_acc
   import mlp_pkg::*;
#(
   parameter int VEC_LEN = 8,
   parameter int ACC_W   = 24
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_clear,
   input  logic              i_add,
   input  logic [PROD_W-1:0] i_value,
   output logic [ACC_W-1:0]  o_acc_next,
   output logic              o_last
);

   localparam int CNT_W = $clog2(VEC_LEN + 1);

   logic [ACC_W-1:0] r_acc;
   logic [CNT_W-1:0] r_recv_cnt;
   logic [ACC_W-1:0] w_acc_next;
   logic [CNT_W-1:0] w_cnt_next;

   // Next values include a product arriving this cycle so the final sum can be
   // captured on the same edge that counts the last product.
   assign w_acc_next = i_add ? r_acc + ACC_W'(i_value) : r_acc;
   assign w_cnt_next = i_add ? r_recv_cnt + CNT_W'(1) : r_recv_cnt;
   assign o_acc_next = w_acc_next;
   assign o_last     = (w_cnt_next == CNT_W'(VEC_LEN));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc      <= '0;
         r_recv_cnt <= '0;
      end else if (i_clear) begin
         r_acc      <= '0;
         r_recv_cnt <= '0;
      end else begin
         r_acc      <= w_acc_next;
         r_recv_cnt <= w_cnt_next;
      end
   end

endmodule

`default_nettype wire

// File: rtl/mac_dot_sequencer.sv
// ============================================================================
//  Module      : mac_dot_sequencer
//  Description : Issues operand pairs to the 2-stage MAC and sums the products.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_dot_sequencer
   import mlp_pkg::*;
#(
   parameter int VEC_LEN = 8,
   parameter int ACC_W   = 24
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [OP_W-1:0]   in_a,
   input  logic [OP_W-1:0]   in_b,
   output logic              mac_enable,
   output logic [OP_W-1:0]   mac_a,
   output logic [OP_W-1:0]   mac_b,
   input  logic [PROD_W-1:0] mac_result,
   input  logic              mac_done,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_sum,
   output logic              busy
);

   localparam int CNT_W = $clog2(VEC_LEN + 1);

   state_t           r_state;
   state_t           w_state_next;
   logic [CNT_W-1:0] r_issue_cnt;
   logic             r_out_valid;
   logic [ACC_W-1:0] r_out_sum;

   logic             w_issue_ok;
   logic             w_fire;
   logic             w_clear;
   logic             w_add;
   logic             w_last;
   logic             w_capture;
   logic [ACC_W-1:0] w_acc_next;

   assign w_issue_ok = (r_state == ISSUE) && (r_issue_cnt < CNT_W'(VEC_LEN));
   assign w_fire     = in_valid && w_issue_ok;
   assign w_clear    = (r_state == IDLE) && start;
   // Products arriving outside an active dot product are stale and dropped.
   assign w_add      = mac_done && ((r_state == ISSUE) || (r_state == DRAIN));
   assign w_capture  = (r_state == DRAIN) && w_last;

   assign in_ready   = w_issue_ok;
   assign mac_enable = w_fire;
   assign mac_a      = w_fire ? in_a : '0;
   assign mac_b      = w_fire ? in_b : '0;
   assign out_valid  = r_out_valid;
   assign out_sum    = r_out_sum;
   assign busy       = (r_state != IDLE);

   dot_acc #(
      .VEC_LEN (VEC_LEN),
      .ACC_W   (ACC_W)
   ) u_dot_acc (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_clear    (w_clear),
      .i_add      (w_add),
      .i_value    (mac_result),
      .o_acc_next (w_acc_next),
      .o_last     (w_last)
   );

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (start) w_state_next = ISSUE;
         ISSUE:   if (w_fire && (r_issue_cnt == CNT_W'(VEC_LEN - 1))) w_state_next = DRAIN;
         DRAIN:   if (w_last) w_state_next = OUTPUT;
         OUTPUT:  if (out_ready) w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_issue_cnt <= '0;
         r_out_valid <= 1'b0;
         r_out_sum   <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_clear) begin
            r_issue_cnt <= '0;
         end else if (w_fire) begin
            r_issue_cnt <= r_issue_cnt + CNT_W'(1);
         end
         if (w_capture) begin
            r_out_valid <= 1'b1;
            r_out_sum   <= w_acc_next;
         end else if ((r_state == OUTPUT) && out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mac_dot_sequencer.sv
// ============================================================================
//  Module      : tb_mac_dot_sequencer
//  Description : Scoreboard bench for mac_dot_sequencer with a 2-stage MAC model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mac_dot_sequencer;

   localparam int VL = 8;

   logic        clk       = 1'b0;
   logic        rst_n     = 1'b0;
   logic        start     = 1'b0;
   logic        in_valid  = 1'b0;
   logic        out_ready = 1'b1;
   logic [7:0]  in_a      = '0;
   logic [7:0]  in_b      = '0;

   logic        in_ready, mac_enable, out_valid, busy;
   logic [7:0]  mac_a, mac_b;
   logic [23:0] out_sum;
   logic        in_ready2, mac_enable2, out_valid2, busy2;
   logic [7:0]  mac_a2, mac_b2;
   logic [15:0] out_sum2;

   // MAC pipeline model: never reset, so in-flight products outlive a DUT reset
   logic        s1_v = 1'b0, s2_v = 1'b0;
   logic [15:0] s1_p = '0, s2_p = '0;
   logic        mac_done;
   logic [15:0] mac_result;

   int          n_chk = 0, n_pass = 0, cyc = 0, n_pop = 0;
   int          rise_cyc = -1, start_cyc = 0;
   logic        prev_ov = 1'b0;
   logic [31:0] sb[$];
   logic [7:0]  va [VL];
   logic [7:0]  vb [VL];

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc++;
      s1_v <= mac_enable;
      s1_p <= 16'(mac_a) * 16'(mac_b);
      s2_v <= s1_v;
      s2_p <= s1_p;
   end
   assign mac_done   = s2_v;
   assign mac_result = s2_p;

   mac_dot_sequencer #(.VEC_LEN(VL), .ACC_W(24)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .mac_enable(mac_enable), .mac_a(mac_a), .mac_b(mac_b),
      .mac_result(mac_result), .mac_done(mac_done), .out_valid(out_valid),
      .out_ready(out_ready), .out_sum(out_sum), .busy(busy)
   );

   mac_dot_sequencer #(.VEC_LEN(VL), .ACC_W(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready2),
      .in_a(in_a), .in_b(in_b), .mac_enable(mac_enable2), .mac_a(mac_a2), .mac_b(mac_b2),
      .mac_result(mac_result), .mac_done(mac_done), .out_valid(out_valid2),
      .out_ready(out_ready), .out_sum(out_sum2), .busy(busy2)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   always @(negedge clk) begin
      logic [31:0] e;
      if (out_valid && !prev_ov) rise_cyc = cyc;
      prev_ov = out_valid;
      if (out_valid && out_ready) begin
         if (sb.size() == 0) begin
            check("unexpected_output", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            check("out_sum", 32'(out_sum), e & 32'hFF_FFFF);
            check("out_sum_w16", 32'(out_sum2), e & 32'hFFFF);
            check("out_valid_w16", 32'(out_valid2), 32'd1);
         end
         n_pop++;
      end
   end

   task automatic do_start();
      start     = 1'b1;
      start_cyc = cyc;
      @(posedge clk); #1;
      start     = 1'b0;
   endtask

   // Drives va/vb[0..n-1]; a full vector's expected sum goes to the scoreboard.
   task automatic feed(input int n, input bit gap);
      int          idx = 0, guard = 0;
      bit          phase = 1'b0, hs;
      logic [31:0] e = 0;
      if (n == VL) begin
         for (int i = 0; i < VL; i++) e += 32'(va[i]) * 32'(vb[i]);
         sb.push_back(e);
      end
      while (idx < n && guard < 200) begin
         in_valid = gap ? phase : 1'b1;
         in_a     = va[idx];
         in_b     = vb[idx];
         @(negedge clk);
         hs = in_valid && in_ready;
         @(posedge clk); #1;
         if (hs) idx++;
         phase = ~phase;
         guard++;
      end
      in_valid = 1'b0;
      if (idx < n) check("feed_timeout", 32'(idx), 32'(n));
   endtask

   task automatic wait_out();
      int target = n_pop + 1;
      int g = 0;
      while (n_pop < target && g < 100) begin
         @(posedge clk);
         g++;
      end
      if (n_pop < target) check("out_timeout", 32'(n_pop), 32'(target));
      #1;
   endtask

   task automatic fill(input int a0, input int b0, input bit ramp);
      for (int i = 0; i < VL; i++) begin
         va[i] = 8'(ramp ? a0 + i : a0);
         vb[i] = 8'(ramp ? b0 + i : b0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      in_valid = 1'b1;
      in_a     = 8'd7;
      #3;
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_out_sum", 32'(out_sum), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_in_ready", 32'(in_ready), 0);
      check("rst_mac_enable", 32'(mac_enable), 0);
      check("rst_mac_a", 32'(mac_a), 0);
      in_valid = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Ramp (i,i): 204, latency 11, single-cycle out_valid
      fill(1, 1, 1'b1);
      do_start();
      feed(VL, 1'b0);
      wait_out();
      check("latency", 32'(rise_cyc - start_cyc), 32'd11);
      @(negedge clk);
      check("out_valid_one_cycle", 32'(out_valid), 0);
      @(posedge clk); #1;

      // All-ones maximum products: 520200, and 0xF008 at 16 bits
      fill(255, 255, 1'b0);
      do_start();
      feed(VL, 1'b0);
      wait_out();

      // Bubbled input (3,5): 120, in_ready low after 8th accept
      fill(3, 5, 1'b0);
      do_start();
      feed(VL, 1'b1);
      @(negedge clk);
      check("in_ready_after_last", 32'(in_ready), 0);
      wait_out();

      // Back-pressure: held output, start ignored, busy throughout
      out_ready = 1'b0;
      fill(4, 4, 1'b0);
      do_start();
      feed(VL, 1'b0);
      begin
         int g = 0;
         do begin
            @(negedge clk);
            g++;
         end while (!out_valid && g < 50);
         check("hold_valid_seen", 32'(out_valid), 1);
      end
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         start = (i == 1);
         @(negedge clk);
         check("hold_out_valid", 32'(out_valid), 1);
         check("hold_out_sum", 32'(out_sum), 32'd128);
         check("hold_busy", 32'(busy), 1);
      end
      @(posedge clk); #1;
      start     = 1'b0;
      out_ready = 1'b1;
      wait_out();
      @(negedge clk);
      check("post_hs_busy", 32'(busy), 0);
      check("post_hs_out_valid", 32'(out_valid), 0);
      check("post_hs_out_sum_kept", 32'(out_sum), 32'd128);
      repeat (3) @(posedge clk);
      #1;
      check("start_in_output_ignored", 32'(busy), 0);

      // Reset mid-operation after 4 pairs, then a clean (1,2) run: 16
      fill(1, 2, 1'b0);
      do_start();
      feed(4, 1'b0);
      in_valid = 1'b1;
      rst_n    = 1'b0;
      #1;
      check("abort_busy", 32'(busy), 0);
      check("abort_in_ready", 32'(in_ready), 0);
      check("abort_mac_enable", 32'(mac_enable), 0);
      check("abort_mac_a", 32'(mac_a), 0);
      check("abort_out_sum", 32'(out_sum), 0);
      check("abort_out_valid", 32'(out_valid), 0);
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      do_start();
      feed(VL, 1'b0);
      wait_out();

      // Consecutive products: 8 then 16
      fill(1, 1, 1'b0);
      do_start();
      feed(VL, 1'b0);
      wait_out();
      fill(2, 1, 1'b0);
      do_start();
      feed(VL, 1'b0);
      wait_out();

      check("scoreboard_drained", 32'(sb.size()), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
